// File: rtl/escalonador_multiplicador.sv
// Round-robin scheduler/sequencer for the shared 8x8 saturating shift-add multiplier.
// Arbitrates two requesters, runs one multiply at a time and aborts it if Pronto never arrives.
module escalonador_multiplicador #(
  parameter int TIMEOUT = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       overflow,
  output logic       error,
  output logic       busy,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  output logic       mul_start,
  input  logic [7:0] mul_result,
  input  logic       mul_overflow,
  input  logic       mul_pronto
);

  localparam int                WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic            last, last_nx;
  logic            winner, winner_nx;
  logic            grant;
  logic [WD_W-1:0] wdog, wdog_nx;
  logic [7:0]      mul_a_nx, mul_b_nx;
  logic            start_nx, done0_nx, done1_nx;
  logic [7:0]      result_nx;
  logic            overflow_nx, error_nx;

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_nx    = state;
    last_nx     = last;
    winner_nx   = winner;
    grant       = 1'b0;
    wdog_nx     = wdog;
    mul_a_nx    = mul_a;
    mul_b_nx    = mul_b;
    start_nx    = 1'b0;
    done0_nx    = 1'b0;
    done1_nx    = 1'b0;
    result_nx   = result;
    overflow_nx = overflow;
    error_nx    = error;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          grant     = (req0 && req1) ? ~last : req1;
          winner_nx = grant;
          last_nx   = grant;
          mul_a_nx  = grant ? a1 : a0;
          mul_b_nx  = grant ? b1 : b0;
          wdog_nx   = '0;
          start_nx  = 1'b1;
          state_nx  = START;
        end
      end
      START: begin
        // Pronto is stale here: the multiplier only clears at the end of this cycle.
        state_nx = WAIT;
      end
      WAIT: begin
        if (mul_pronto) begin
          result_nx   = mul_result;
          overflow_nx = mul_overflow;
          error_nx    = 1'b0;
          done0_nx    = ~winner;
          done1_nx    = winner;
          state_nx    = DONE;
        end else if (wdog == WD_LAST) begin
          result_nx   = 8'hFF;
          overflow_nx = 1'b1;
          error_nx    = 1'b1;
          done0_nx    = ~winner;
          done1_nx    = winner;
          state_nx    = DONE;
        end else begin
          wdog_nx = wdog + WD_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      winner    <= 1'b0;
      wdog      <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      winner    <= winner_nx;
      wdog      <= wdog_nx;
      mul_a     <= mul_a_nx;
      mul_b     <= mul_b_nx;
      mul_start <= start_nx;
      done0     <= done0_nx;
      done1     <= done1_nx;
      result    <= result_nx;
      overflow  <= overflow_nx;
      error     <= error_nx;
    end
  end

endmodule

// File: tb/tb_escalonador_multiplicador.sv
// Bench for escalonador_multiplicador: behavioural multiplier, latency-formula reference model
// compared every cycle, and directed operations with hand-computed results.
module tb_escalonador_multiplicador;

  localparam int TIMEOUT = 300;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       done0, done1;
  logic [7:0] result;
  logic       overflow, error, busy;
  logic [7:0] mul_a, mul_b;
  logic       mul_start;
  logic [7:0] mul_result;
  logic       mul_overflow;
  logic       mul_pronto;

  escalonador_multiplicador #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .done0        (done0),
    .done1        (done1),
    .result       (result),
    .overflow     (overflow),
    .error        (error),
    .busy         (busy),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_start    (mul_start),
    .mul_result   (mul_result),
    .mul_overflow (mul_overflow),
    .mul_pronto   (mul_pronto)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  bit pronto_dead = 1'b0;
  int done0_cnt = 0;
  int done1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Shared multiplier: counter/accumulator cleared by START, Pronto = (counter == B).
  // Pronto is also driven high during the START cycle to imitate a stale value.
  logic [7:0] mm_cnt = 8'd0;
  logic [7:0] mm_acc = 8'd0;
  logic       mm_sat = 1'b0;

  always @(posedge clock) begin
    if (mul_start) begin
      mm_cnt <= 8'd0;
      mm_acc <= 8'd0;
      mm_sat <= 1'b0;
    end else if (mm_cnt != mul_b) begin
      mm_cnt <= mm_cnt + 8'd1;
      mm_acc <= ((int'(mm_acc) + int'(mul_a)) > 255) ? 8'hFF : mm_acc + mul_a;
      mm_sat <= mm_sat || ((int'(mm_acc) + int'(mul_a)) > 255);
    end
  end

  assign mul_result   = mm_acc;
  assign mul_overflow = mm_sat;
  assign mul_pronto   = !pronto_dead && ((mm_cnt == mul_b) || mul_start);

  // Reference model: on accept, compute the whole operation from the latency formula
  // (DONE at 3+B, or 2+TIMEOUT on abort) and the saturated product A*B.
  bit m_active = 1'b0;
  int m_age    = 0;
  int m_len    = 0;
  bit m_win    = 1'b0;
  bit m_last   = 1'b1;
  bit m_dead   = 1'b0;
  int m_a      = 0;
  int m_b      = 0;
  int m_res    = 0;
  bit m_ovf    = 1'b0;
  bit m_err    = 1'b0;

  function automatic bit pick(input logic r0, input logic r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_last   <= 1'b1;
      m_a      <= 0;
      m_b      <= 0;
      m_res    <= 0;
      m_ovf    <= 1'b0;
      m_err    <= 1'b0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_win    <= pick(req0, req1, m_last);
        m_last   <= pick(req0, req1, m_last);
        m_a      <= pick(req0, req1, m_last) ? int'(a1) : int'(a0);
        m_b      <= pick(req0, req1, m_last) ? int'(b1) : int'(b0);
        m_dead   <= pronto_dead;
        m_len    <= pronto_dead ? TIMEOUT + 2
                                : 3 + (pick(req0, req1, m_last) ? int'(b1) : int'(b0));
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == m_len - 1) begin
        m_res <= m_dead ? 255 : ((m_a * m_b > 255) ? 255 : m_a * m_b);
        m_ovf <= m_dead ? 1'b1 : (m_a * m_b > 255);
        m_err <= m_dead;
      end
      if (m_age == m_len) m_active <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (done0) done0_cnt <= done0_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (chk_en) begin
      check("busy",      busy,      m_active);
      check("mul_start", mul_start, m_active && m_age == 1);
      check("done0",     done0,     m_active && m_age == m_len && !m_win);
      check("done1",     done1,     m_active && m_age == m_len && m_win);
      check("mul_a",     mul_a,     m_a);
      check("mul_b",     mul_b,     m_b);
      check("result",    result,    m_res);
      check("overflow",  overflow,  m_ovf);
      check("error",     error,     m_err);
    end
  end

  // One operation from one requester: raise REQ in an IDLE cycle, scramble the operands
  // after accept, drop REQ in the DONE cycle, then check latency and outputs literally.
  task automatic run_op(input bit id, input int a, input int b, input int lat,
                        input int res, input bit ovf, input bit err, input string name);
    int  acc_cyc;
    int  got_lat;
    int  other_before;
    bit  seen;
    @(posedge clock); #1;
    if (id) begin a1 = 8'(a); b1 = 8'(b); req1 = 1'b1; end
    else    begin a0 = 8'(a); b0 = 8'(b); req0 = 1'b1; end
    acc_cyc      = cyc;
    other_before = id ? done0_cnt : done1_cnt;
    seen         = 1'b0;
    got_lat      = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clock); #1;
      if (cyc == acc_cyc + 1) begin
        if (id) begin a1 = 8'($urandom); b1 = 8'($urandom); end
        else    begin a0 = 8'($urandom); b0 = 8'($urandom); end
      end
      if (id ? done1 : done0) begin
        seen    = 1'b1;
        got_lat = cyc - acc_cyc;
        if (id) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) begin
      check({name, "_latency"},  got_lat,  lat);
      check({name, "_result"},   result,   res);
      check({name, "_overflow"}, overflow, ovf);
      check({name, "_error"},    error,    err);
      check({name, "_other_done"}, id ? done0_cnt : done1_cnt, other_before);
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    int g[$];
    int start_cnt;
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    check("rst_busy",      busy,      0);
    check("rst_mul_start", mul_start, 0);
    check("rst_result",    result,    0);
    check("rst_mul_a",     mul_a,     0);
    check("rst_error",     error,     0);
    reset = 1'b1;

    run_op(1'b0, 12, 10, 13, 120, 1'b0, 1'b0, "basic");
    run_op(1'b1, 20, 20, 23, 255, 1'b1, 1'b0, "sat");
    run_op(1'b0, 3, 5, 8, 15, 1'b0, 1'b0, "pre_b0");
    run_op(1'b0, 77, 0, 3, 0, 1'b0, 1'b0, "b_zero");
    run_op(1'b1, 1, 255, 258, 255, 1'b0, 1'b0, "b_max");
    run_op(1'b0, 16, 16, 19, 255, 1'b1, 1'b0, "sat_256");
    run_op(1'b1, 15, 17, 20, 255, 1'b0, 1'b0, "exact_255");

    // Fairness: both requesters hold REQ, each drops it only in its own DONE cycle.
    do_reset();
    a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5;
    @(posedge clock); #1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 300 && g.size() < 4; i++) begin
      @(posedge clock); #1;
      if (done0) begin g.push_back(0); check("fair_res0", result, 6); end
      if (done1) begin g.push_back(1); check("fair_res1", result, 20); end
      req0 = !done0;
      req1 = !done1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("fair_count", g.size(), 4);
    if (g.size() == 4) begin
      check("fair_g0", g[0], 0);
      check("fair_g1", g[1], 1);
      check("fair_g2", g[2], 0);
      check("fair_g3", g[3], 1);
    end

    // Reset in the middle of a long operation.
    @(posedge clock); #1;
    a0 = 8'd9; b0 = 8'd200; req0 = 1'b1;
    start_cnt = done0_cnt;
    repeat (50) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; req0 = 1'b0;
    check("midrst_busy",      busy,      0);
    check("midrst_mul_start", mul_start, 0);
    check("midrst_result",    result,    0);
    repeat (300) @(posedge clock);
    #1 check("midrst_no_done", done0_cnt, start_cnt);
    run_op(1'b0, 5, 5, 8, 25, 1'b0, 1'b0, "after_rst");

    // Watchdog abort, then a normal operation clears ERROR.
    pronto_dead = 1'b1;
    run_op(1'b0, 7, 7, TIMEOUT + 2, 255, 1'b1, 1'b1, "watchdog");
    pronto_dead = 1'b0;
    run_op(1'b1, 3, 4, 7, 12, 1'b0, 1'b0, "post_wd");

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
